// File: rtl/ar_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ar_scan_pkg
// Purpose  : Shared types and constants for the ar_mux_scan sequencing stage.
// Revision : 1.0 - initial release
// ============================================================================
package ar_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ar_scan_next_ch.sv
`default_nettype none
// ============================================================================
// Module   : ar_scan_next_ch
// Purpose  : Priority search for the lowest set mask bit strictly above sel,
//            or anywhere in the mask when from_start is set.
// Revision : 1.0 - initial release
// ============================================================================
module ar_scan_next_ch
    import ar_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  sel,
    input  logic              from_start,
    output logic [SEL_W-1:0]  next_ch,
    output logic              none
);

    // Walk from the top down so the lowest qualifying bit wins.
    always_comb begin
        next_ch = '0;
        none    = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (i > int'(sel)))) begin
                next_ch = SEL_W'(i);
                none    = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ar_mux_scan.sv
`default_nettype none
// ============================================================================
// Module   : ar_mux_scan
// Purpose  : Scans the enabled channels of a 4:1 mux, dwelling DWELL cycles on
//            each, and returns the captured bits with a valid/ready handshake.
//            Optional parity output enabled by AR_MUX_SCAN_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ar_mux_scan
    import ar_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [SEL_W-1:0]  sel,
    output logic              enable,
    input  logic              y,
    output logic [NUM_CH-1:0] sample,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              busy
`ifdef AR_MUX_SCAN_PARITY_EN
    ,
    output logic              sample_par
`endif
);

    localparam logic [CNT_W-1:0] c_dwell_last = CNT_W'(DWELL - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SEL_W-1:0]  r_sel;
    logic [CNT_W-1:0]  r_cnt;
    logic [NUM_CH-1:0] r_mask;
    logic [NUM_CH-1:0] r_sample;
    logic [NUM_CH-1:0] w_sample_cap;
    logic [SEL_W-1:0]  w_first_ch;
    logic              w_first_none;
    logic [SEL_W-1:0]  w_next_ch;
    logic              w_next_none;
    logic              w_last;
    logic              w_accept;

    ar_scan_next_ch u_first (
        .mask       (ch_mask),
        .sel        ('0),
        .from_start (1'b1),
        .next_ch    (w_first_ch),
        .none       (w_first_none)
    );

    ar_scan_next_ch u_next (
        .mask       (r_mask),
        .sel        (r_sel),
        .from_start (1'b0),
        .next_ch    (w_next_ch),
        .none       (w_next_none)
    );

    assign w_last   = (r_cnt == c_dwell_last);
    assign w_accept = (r_state == IDLE) && start;

    always_comb begin
        w_sample_cap        = r_sample;
        w_sample_cap[r_sel] = y;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        enable       = 1'b0;
        busy         = 1'b0;
        sample_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = w_first_none ? DONE : SCAN;
                end
            end
            SCAN: begin
                enable = 1'b1;
                busy   = 1'b1;
                if (w_last && w_next_none) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy         = 1'b1;
                sample_valid = 1'b1;
                if (sample_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel    <= '0;
            r_cnt    <= '0;
            r_mask   <= '0;
            r_sample <= '0;
        end else if (w_accept) begin
            r_mask   <= ch_mask;
            r_sample <= '0;
            r_cnt    <= '0;
            if (!w_first_none) begin
                r_sel <= w_first_ch;
            end
        end else if (r_state == SCAN) begin
            if (w_last) begin
                r_cnt    <= '0;
                r_sample <= w_sample_cap;
                if (!w_next_none) begin
                    r_sel <= w_next_ch;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign sel    = r_sel;
    assign sample = r_sample;

`ifdef AR_MUX_SCAN_PARITY_EN
    logic r_par;

    // Tracks the parity of whatever is written into r_sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (w_accept) begin
            r_par <= 1'b0;
        end else if ((r_state == SCAN) && w_last) begin
            r_par <= ^w_sample_cap;
        end
    end

    assign sample_par = r_par;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ar_mux_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_ar_mux_scan
// Purpose  : Self-checking bench for ar_mux_scan with a behavioural 4:1 mux.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ar_mux_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] ch_mask = 4'b0000;
    logic [1:0] sel;
    logic       enable;
    logic       y;
    logic [3:0] sample;
    logic       sample_valid;
    logic       sample_ready = 1'b0;
    logic       busy;
    logic [3:0] a = 4'b0000;
`ifdef AR_MUX_SCAN_PARITY_EN
    logic       sample_par;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign y = enable ? a[sel] : 1'b0;

    ar_mux_scan #(.DWELL(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .ch_mask      (ch_mask),
        .sel          (sel),
        .enable       (enable),
        .y            (y),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy)
`ifdef AR_MUX_SCAN_PARITY_EN
        ,
        .sample_par   (sample_par)
`endif
    );

    typedef struct {
        logic [3:0]  a;
        logic [3:0]  mask;
        logic [15:0] seq;
        int          len;
        logic [3:0]  exp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start a scan, log the sel of every enabled cycle, then check and accept the result.
    task automatic run_scan(input vec_t v);
        logic [15:0] obs;
        int          n;
        bit          got;
        obs = '0;
        n   = 0;
        got = 1'b0;
        @(negedge clk);
        a       = v.a;
        ch_mask = v.mask;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        ch_mask = ~v.mask;
        for (int c = 0; c < 40 && !got; c++) begin
            if (sample_valid) begin
                got = 1'b1;
            end else begin
                if (enable) begin
                    if (n < 8) obs = obs | (16'(sel) << (2 * n));
                    n++;
                end
                @(negedge clk);
            end
        end
        chk("scan_reached_done", 32'(got), 32'd1);
        chk("sel_sequence", 32'(obs), 32'(v.seq));
        chk("enable_cycles", n, v.len);
        chk("sample", 32'(sample), 32'(v.exp));
        chk("busy_in_done", 32'(busy), 32'd1);
        chk("enable_in_done", 32'(enable), 32'd0);
`ifdef AR_MUX_SCAN_PARITY_EN
        chk("sample_par", 32'(sample_par), 32'(^v.exp));
`endif
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        chk("valid_cleared", 32'(sample_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'b0101, 4'b1111, 16'hFA50, 8, 4'b0101};
        vecs[1] = '{4'b1111, 4'b1010, 16'h00F5, 4, 4'b1010};
        vecs[2] = '{4'b1111, 4'b0000, 16'h0000, 0, 4'b0000};
        vecs[3] = '{4'b1001, 4'b0110, 16'h00A5, 4, 4'b0000};
        vecs[4] = '{4'b1110, 4'b1001, 16'h00F0, 4, 4'b1000};
        vecs[5] = '{4'b0111, 4'b1111, 16'hFA50, 8, 4'b0111};

        #12;
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_enable", 32'(enable), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_sample", 32'(sample), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_scan(vecs[i]);

        // Result held while downstream stalls; start in DONE and with the handshake is ignored.
        @(negedge clk);
        a       = 4'b0110;
        ch_mask = 4'b1111;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 40 && !sample_valid; c++) @(negedge clk);
        chk("hold_reached_done", 32'(sample_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("hold_sample", 32'(sample), 32'h6);
            chk("hold_valid", 32'(sample_valid), 32'd1);
            start = (k == 2);
            @(negedge clk);
        end
        start = 1'b0;
        chk("hold_after_start", 32'(sample), 32'h6);
        sample_ready = 1'b1;
        start        = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        start        = 1'b0;
        chk("handshake_valid", 32'(sample_valid), 32'd0);
        chk("handshake_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("start_ignored_busy", 32'(busy), 32'd0);
        chk("start_ignored_enable", 32'(enable), 32'd0);

        // Asynchronous reset in the middle of a scan.
        a       = 4'b1111;
        ch_mask = 4'b1111;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20 && !(enable && sel == 2'd2); c++) @(negedge clk);
        chk("midscan_sel2", 32'(sel), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sel", 32'(sel), 32'd0);
        chk("arst_enable", 32'(enable), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(sample_valid), 32'd0);
        chk("arst_sample", 32'(sample), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_scan(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
